lift_step_seq: RTL and testbench

- Lifting-step sequencer for the 5/3 wavelet. Sits directly downstream of the even/odd pixel RAM pair (128 x 20-bit each) and drives its address, write-enable and data-in ports.
- On start, walks one half-row and performs one lifting pass in place: predict (updates the odd RAM) or update (updates the even RAM), forward or inverse.
- Upper-level control issues predict then update (forward), or update then predict (inverse).

---
 rtl/lift_step_seq.sv | 142 ++++++++++++++
 tb/tb_lift_step_seq.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lift_step_seq.sv
// 5/3 wavelet lifting-step sequencer: one in-place predict or update pass over an even/odd RAM pair.
// Define LIFT_SAT_EN to saturate write-back results instead of wrapping them modulo 2**W.
module lift_step_seq #(
    parameter int unsigned W  = 20,
    parameter int unsigned AW = 7,
    parameter int unsigned N  = 128
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          fwd_inv,
    input  logic          p,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] even_addr,
    output logic          even_we,
    output logic [W-1:0]  even_din,
    input  logic [W-1:0]  even_dout,
    output logic [AW-1:0] odd_addr,
    output logic          odd_we,
    output logic [W-1:0]  odd_din,
    input  logic [W-1:0]  odd_dout
);

    localparam int unsigned SW = W + 2;
    localparam logic [AW-1:0] LAST = AW'(N - 1);
`ifdef LIFT_SAT_EN
    localparam logic signed [SW-1:0] SAT_MAX = $signed({3'b000, {(W-1){1'b1}}});
    localparam logic signed [SW-1:0] SAT_MIN = $signed({3'b111, {(W-1){1'b0}}});
`endif

    typedef enum logic [1:0] {S_IDLE, S_RDA, S_RDB, S_WB} state_t;

    state_t                r_state;
    logic [AW-1:0]         r_idx;
    logic                  r_fwd;
    logic                  r_p;
    logic signed [W-1:0]   r_t;
    logic signed [W-1:0]   r_a;
    logic [W-1:0]          r_even_din;
    logic [W-1:0]          r_odd_din;

    logic [AW-1:0]         w_idx_next_clamp;
    logic signed [W-1:0]   w_b;
    logic signed [SW-1:0]  w_sum;
    logic signed [SW-1:0]  w_d;
    logic signed [SW-1:0]  w_full;
    logic [W-1:0]          w_res;

    // Lifting arithmetic on the operand arriving in WB; the write data must see it the same cycle.
    always_comb begin
        w_idx_next_clamp = (r_idx == LAST) ? r_idx : r_idx + AW'(1);
        w_b   = r_p ? $signed(even_dout) : $signed(odd_dout);
        w_sum = SW'(r_a) + SW'(w_b);
        if (r_p) w_d = w_sum >>> 1;
        else     w_d = (w_sum + SW'(2)) >>> 2;
        if (r_p == r_fwd) w_full = SW'(r_t) - w_d;
        else              w_full = SW'(r_t) + w_d;
`ifdef LIFT_SAT_EN
        if (w_full > SAT_MAX)      w_res = W'(SAT_MAX);
        else if (w_full < SAT_MIN) w_res = W'(SAT_MIN);
        else                       w_res = W'(w_full);
`else
        w_res = W'(w_full);
`endif
    end

    assign even_din = (r_state == S_WB && !r_p) ? w_res : r_even_din;
    assign odd_din  = (r_state == S_WB &&  r_p) ? w_res : r_odd_din;

    // Addresses are registered one state ahead so read data lands in the following state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_fwd      <= 1'b0;
            r_p        <= 1'b0;
            r_t        <= '0;
            r_a        <= '0;
            r_even_din <= '0;
            r_odd_din  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            even_addr  <= '0;
            odd_addr   <= '0;
            even_we    <= 1'b0;
            odd_we     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_fwd     <= fwd_inv;
                        r_p       <= p;
                        r_idx     <= '0;
                        busy      <= 1'b1;
                        even_addr <= '0;
                        odd_addr  <= '0;
                        r_state   <= S_RDA;
                    end
                end
                S_RDA: begin
                    if (r_p) even_addr <= w_idx_next_clamp;
                    else     odd_addr  <= r_idx;
                    r_state <= S_RDB;
                end
                S_RDB: begin
                    if (r_p) begin
                        r_t      <= $signed(odd_dout);
                        r_a      <= $signed(even_dout);
                        odd_addr <= r_idx;
                        odd_we   <= 1'b1;
                    end else begin
                        r_t       <= $signed(even_dout);
                        r_a       <= $signed(odd_dout);
                        even_addr <= r_idx;
                        even_we   <= 1'b1;
                    end
                    r_state <= S_WB;
                end
                S_WB: begin
                    even_we <= 1'b0;
                    odd_we  <= 1'b0;
                    if (r_p) r_odd_din  <= w_res;
                    else     r_even_din <= w_res;
                    if (r_idx == LAST) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_idx     <= r_idx + AW'(1);
                        even_addr <= r_idx + AW'(1);
                        odd_addr  <= r_p ? r_idx + AW'(1) : r_idx;
                        r_state   <= S_RDA;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lift_step_seq.sv
// Self-checking bench for lift_step_seq: RAM pair model plus an array-level lifting reference.
module tb_lift_step_seq;

    localparam int unsigned W  = 20;
    localparam int unsigned AW = 7;
    localparam int unsigned N  = 128;
    localparam int MAXS = (1 << (W - 1)) - 1;
    localparam int MINS = -(1 << (W - 1));

    logic          clk = 1'b0;
    logic          rst, start, fwd_inv, p;
    logic          busy, done, even_we, odd_we;
    logic [AW-1:0] even_addr, odd_addr;
    logic [W-1:0]  even_din, odd_din, even_dout, odd_dout;

    logic          ld_en;
    logic [AW-1:0] ld_addr;
    logic [W-1:0]  ld_e, ld_o;
    logic [W-1:0]  mem_e [N];
    logic [W-1:0]  mem_o [N];

    int ref_e [N];
    int ref_o [N];
    int n_checks = 0;
    int n_fail   = 0;
    int bc, dc, bad_we, tgt_we;
    bit first_busy, tmo;

    always #5 clk = ~clk;

    lift_step_seq #(.W(W), .AW(AW), .N(N)) dut (
        .clk(clk), .rst(rst), .start(start), .fwd_inv(fwd_inv), .p(p),
        .busy(busy), .done(done),
        .even_addr(even_addr), .even_we(even_we), .even_din(even_din), .even_dout(even_dout),
        .odd_addr(odd_addr), .odd_we(odd_we), .odd_din(odd_din), .odd_dout(odd_dout)
    );

    // Synchronous-read RAM pair with a bench-side load port.
    always @(posedge clk) begin
        if (ld_en) begin
            mem_e[ld_addr] <= ld_e;
            mem_o[ld_addr] <= ld_o;
        end
        if (even_we) mem_e[even_addr] <= even_din;
        if (odd_we)  mem_o[odd_addr]  <= odd_din;
        even_dout <= mem_e[even_addr];
        odd_dout  <= mem_o[odd_addr];
    end

    function automatic int sv(input logic [W-1:0] x);
        return int'($signed(x));
    endfunction

    function automatic longint fdiv(input longint x, input longint m);
        longint r;
        r = x % m;
        if (r < 0) r += m;
        return (x - r) / m;
    endfunction

    function automatic int fit(input longint v);
`ifdef LIFT_SAT_EN
        if (v > MAXS) return MAXS;
        if (v < MINS) return MINS;
        return int'(v);
`else
        longint span, half, r;
        span = longint'(1) << W;
        half = longint'(1) << (W - 1);
        r = (v + half) % span;
        if (r < 0) r += span;
        return int'(r - half);
`endif
    endfunction

    function automatic int rnd_sample();
        case ($urandom_range(0, 7))
            0:       return MINS;
            1:       return MAXS;
            default: return sv(W'($urandom));
        endcase
    endfunction

    // Whole-array reference: new values depend only on the pre-pass arrays.
    task automatic model_pass(input bit fwd, input bit pp);
        int ne [N];
        int no [N];
        longint d;
        for (int k = 0; k < int'(N); k++) begin
            ne[k] = ref_e[k];
            no[k] = ref_o[k];
        end
        for (int k = 0; k < int'(N); k++) begin
            if (pp) begin
                d = fdiv(longint'(ref_e[k]) + longint'(ref_e[(k == int'(N) - 1) ? k : k + 1]), 2);
                no[k] = fit(fwd ? longint'(ref_o[k]) - d : longint'(ref_o[k]) + d);
            end else begin
                d = fdiv(longint'(ref_o[(k == 0) ? 0 : k - 1]) + longint'(ref_o[k]) + 2, 4);
                ne[k] = fit(fwd ? longint'(ref_e[k]) + d : longint'(ref_e[k]) - d);
            end
        end
        for (int k = 0; k < int'(N); k++) begin
            ref_e[k] = ne[k];
            ref_o[k] = no[k];
        end
    endtask

    task automatic load_mem();
        for (int k = 0; k < int'(N); k++) begin
            ld_en = 1'b1; ld_addr = AW'(k); ld_e = W'(ref_e[k]); ld_o = W'(ref_o[k]);
            @(negedge clk);
        end
        ld_en = 1'b0;
    endtask

    task automatic fill_random();
        for (int k = 0; k < int'(N); k++) begin
            ref_e[k] = rnd_sample();
            ref_o[k] = rnd_sample();
        end
    endtask

    // Issues start at the current negedge and returns at the negedge where done is seen.
    task automatic run_pass(input bit fwd, input bit pp, input int inject_at);
        start = 1'b1; fwd_inv = fwd; p = pp;
        @(negedge clk);
        start = 1'b0;
        bc = 0; dc = 0; bad_we = 0; tgt_we = 0; tmo = 1'b1;
        first_busy = busy;
        for (int c = 0; c < int'(3 * N) + 20; c++) begin
            if (busy) bc++;
            if (done) dc++;
            if (pp ? even_we : odd_we) bad_we++;
            if (pp ? odd_we : even_we) tgt_we++;
            start = (c == inject_at);
            if (c == inject_at) begin fwd_inv = ~fwd; p = ~pp; end
            if (done) begin tmo = 1'b0; break; end
            @(negedge clk);
        end
        start = 1'b0;
        n_checks++;
        if (tmo) begin n_fail++; $display("FAIL pass_timeout: done=%0b busy=%0b, required done pulse", done, busy); end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; fwd_inv = 1'b0; p = 1'b0; ld_en = 1'b0;
        ld_addr = '0; ld_e = '0; ld_o = '0;
        repeat (3) @(negedge clk);
        n_checks++; if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL reset_busy_done: got %b required 00", {busy, done}); end
        n_checks++; if ({even_we, odd_we} !== 2'b00) begin n_fail++; $display("FAIL reset_we: got %b required 00", {even_we, odd_we}); end
        n_checks++; if ({even_addr, odd_addr} !== '0) begin n_fail++; $display("FAIL reset_addr: got %0d/%0d required 0/0", even_addr, odd_addr); end
        n_checks++; if ({even_din, odd_din} !== '0) begin n_fail++; $display("FAIL reset_din: got %0d/%0d required 0/0", even_din, odd_din); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fwd_predict_ramp();
        for (int k = 0; k < int'(N); k++) begin ref_e[k] = 2 * k; ref_o[k] = 2 * k + 1; end
        load_mem();
        model_pass(1'b1, 1'b1);
        run_pass(1'b1, 1'b1, -1);
        n_checks++; if (bc !== 384) begin n_fail++; $display("FAIL ramp_busy_cycles: got %0d required 384", bc); end
        n_checks++; if (dc !== 1) begin n_fail++; $display("FAIL ramp_done_count: got %0d required 1", dc); end
        n_checks++; if (bad_we !== 0) begin n_fail++; $display("FAIL ramp_even_we: got %0d cycles required 0", bad_we); end
        n_checks++; if (tgt_we !== int'(N)) begin n_fail++; $display("FAIL ramp_odd_we: got %0d cycles required %0d", tgt_we, N); end
        for (int k = 0; k < int'(N); k++) begin
            n_checks++;
            if (sv(mem_o[k]) !== ((k == int'(N) - 1) ? 1 : 0) || sv(mem_e[k]) !== 2 * k) begin
                n_fail++; $display("FAIL ramp_ram[%0d]: even=%0d odd=%0d required even=%0d odd=%0d",
                                   k, sv(mem_e[k]), sv(mem_o[k]), 2 * k, (k == int'(N) - 1) ? 1 : 0);
            end
        end
        @(negedge clk);
        n_checks++; if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL ramp_after_done: busy/done=%b required 00", {busy, done}); end
    endtask

    task automatic test_inv_predict();
        model_pass(1'b0, 1'b1);
        run_pass(1'b0, 1'b1, -1);
        n_checks++; if (bad_we !== 0) begin n_fail++; $display("FAIL inv_even_we: got %0d cycles required 0", bad_we); end
        n_checks++; if (dc !== 1) begin n_fail++; $display("FAIL inv_done_count: got %0d required 1", dc); end
        for (int k = 0; k < int'(N); k++) begin
            n_checks++;
            if (sv(mem_o[k]) !== 2 * k + 1 || sv(mem_e[k]) !== ref_e[k]) begin
                n_fail++; $display("FAIL inv_ram[%0d]: even=%0d odd=%0d required even=%0d odd=%0d",
                                   k, sv(mem_e[k]), sv(mem_o[k]), ref_e[k], 2 * k + 1);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_update_boundary();
        for (int k = 0; k < int'(N); k++) begin ref_e[k] = 0; ref_o[k] = 0; end
        ref_o[0] = 8; ref_o[1] = 4;
        load_mem();
        model_pass(1'b1, 1'b0);
        run_pass(1'b1, 1'b0, -1);
        n_checks++; if (bad_we !== 0) begin n_fail++; $display("FAIL upd_odd_we: got %0d cycles required 0", bad_we); end
        n_checks++;
        if (sv(mem_e[0]) !== 4 || sv(mem_e[1]) !== 3 || sv(mem_e[2]) !== 1) begin
            n_fail++; $display("FAIL upd_edge: got %0d %0d %0d required 4 3 1", sv(mem_e[0]), sv(mem_e[1]), sv(mem_e[2]));
        end
        for (int k = 0; k < int'(N); k++) begin
            n_checks++;
            if (sv(mem_e[k]) !== ref_e[k] || sv(mem_o[k]) !== ref_o[k]) begin
                n_fail++; $display("FAIL upd_ram[%0d]: even=%0d odd=%0d required even=%0d odd=%0d",
                                   k, sv(mem_e[k]), sv(mem_o[k]), ref_e[k], ref_o[k]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_overflow();
        int exp_o;
`ifdef LIFT_SAT_EN
        exp_o = 524287;
`else
        exp_o = -1;
`endif
        for (int k = 0; k < int'(N); k++) begin ref_e[k] = -524288; ref_o[k] = 524287; end
        load_mem();
        run_pass(1'b1, 1'b1, -1);
        for (int k = 0; k < int'(N); k++) begin
            n_checks++;
            if (sv(mem_o[k]) !== exp_o) begin
                n_fail++; $display("FAIL ovf_odd[%0d]: got %0d required %0d", k, sv(mem_o[k]), exp_o);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        bit fwd, pp;
        for (int it = 0; it < 4; it++) begin
            fill_random();
            fwd = 1'($urandom); pp = 1'($urandom);
            load_mem();
            model_pass(fwd, pp);
            run_pass(fwd, pp, -1);
            n_checks++; if (bc !== 3 * int'(N) || dc !== 1) begin n_fail++; $display("FAIL rnd%0d_handshake: busy=%0d done=%0d required %0d 1", it, bc, dc, 3 * N); end
            for (int k = 0; k < int'(N); k++) begin
                n_checks++;
                if (sv(mem_e[k]) !== ref_e[k] || sv(mem_o[k]) !== ref_o[k]) begin
                    n_fail++; $display("FAIL rnd%0d_ram[%0d]: even=%0d odd=%0d required even=%0d odd=%0d",
                                       it, k, sv(mem_e[k]), sv(mem_o[k]), ref_e[k], ref_o[k]);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_start_ignored();
        fill_random();
        load_mem();
        model_pass(1'b1, 1'b0);
        run_pass(1'b1, 1'b0, 150);
        n_checks++; if (bc !== 384) begin n_fail++; $display("FAIL ign_busy_cycles: got %0d required 384", bc); end
        n_checks++; if (dc !== 1) begin n_fail++; $display("FAIL ign_done_count: got %0d required 1", dc); end
        for (int k = 0; k < int'(N); k++) begin
            n_checks++;
            if (sv(mem_e[k]) !== ref_e[k] || sv(mem_o[k]) !== ref_o[k]) begin
                n_fail++; $display("FAIL ign_ram[%0d]: even=%0d odd=%0d required even=%0d odd=%0d",
                                   k, sv(mem_e[k]), sv(mem_o[k]), ref_e[k], ref_o[k]);
            end
        end
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ign_restart: busy=%0b required 0", busy); end
    endtask

    // Reset lands in RDA of sample 33: samples 0..32 written, the rest untouched.
    task automatic test_reset_mid_pass();
        int init_o [N];
        int wes, dns, bsy;
        fill_random();
        for (int k = 0; k < int'(N); k++) init_o[k] = ref_o[k];
        load_mem();
        model_pass(1'b1, 1'b1);
        for (int k = 33; k < int'(N); k++) ref_o[k] = init_o[k];
        start = 1'b1; fwd_inv = 1'b1; p = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (99) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %0b required 0", busy); end
        wes = 0; dns = 0; bsy = 0;
        for (int c = 0; c < int'(3 * N); c++) begin
            if (even_we || odd_we) wes++;
            if (done) dns++;
            if (busy) bsy++;
            @(negedge clk);
        end
        n_checks++; if (wes !== 0) begin n_fail++; $display("FAIL rstmid_we: got %0d write cycles required 0", wes); end
        n_checks++; if (dns !== 0) begin n_fail++; $display("FAIL rstmid_done: got %0d pulses required 0", dns); end
        n_checks++; if (bsy !== 0) begin n_fail++; $display("FAIL rstmid_busy_after: got %0d cycles required 0", bsy); end
        for (int k = 0; k < int'(N); k++) begin
            n_checks++;
            if (sv(mem_o[k]) !== ref_o[k] || sv(mem_e[k]) !== ref_e[k]) begin
                n_fail++; $display("FAIL rstmid_ram[%0d]: even=%0d odd=%0d required even=%0d odd=%0d",
                                   k, sv(mem_e[k]), sv(mem_o[k]), ref_e[k], ref_o[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        fill_random();
        load_mem();
        model_pass(1'b1, 1'b1);
        run_pass(1'b1, 1'b1, -1);
        for (int k = 0; k < int'(N); k++) begin
            n_checks++;
            if (sv(mem_o[k]) !== ref_o[k] || sv(mem_e[k]) !== ref_e[k]) begin
                n_fail++; $display("FAIL b2b_a_ram[%0d]: even=%0d odd=%0d required even=%0d odd=%0d",
                                   k, sv(mem_e[k]), sv(mem_o[k]), ref_e[k], ref_o[k]);
            end
        end
        model_pass(1'b1, 1'b0);
        run_pass(1'b1, 1'b0, -1);
        n_checks++; if (first_busy !== 1'b1) begin n_fail++; $display("FAIL b2b_restart: busy=%0b required 1", first_busy); end
        n_checks++; if (bc !== 384 || dc !== 1) begin n_fail++; $display("FAIL b2b_handshake: busy=%0d done=%0d required 384 1", bc, dc); end
        for (int k = 0; k < int'(N); k++) begin
            n_checks++;
            if (sv(mem_o[k]) !== ref_o[k] || sv(mem_e[k]) !== ref_e[k]) begin
                n_fail++; $display("FAIL b2b_b_ram[%0d]: even=%0d odd=%0d required even=%0d odd=%0d",
                                   k, sv(mem_e[k]), sv(mem_o[k]), ref_e[k], ref_o[k]);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_fwd_predict_ramp();
        test_inv_predict();
        test_update_boundary();
        test_overflow();
        test_random();
        test_start_ignored();
        test_reset_mid_pass();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
